mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Memory-side controller directly downstream of the RV32I core's memory port.
//  Turns the core's level read/write strobes into single-cycle accesses on a pipelined synchronous word RAM.
//  Returns read data and the iMemRdy handshake the core's control unit waits on.
//  Four-phase handshake: one RAM access per request, however long the core holds the strobe.
// PARAMETERS
//  ADDR_W       12  RAM word-address width (RAM holds 2^ADDR_W x 32b)
//  RD_LAT        1  RAM read latency, cycles after enable (>=1)
//  WAIT_STATES   0  extra delay cycles appended before the response (>=0)
// PORTS
//  iClk        in   1       clock, rising edge
//  iRst        in   1       synchronous reset, active-high
//  iMemRead    in   1       core read request (level)
//  iMemWrite   in   1       core write request (level)
//  iMemAddr    in   32      core byte address
//  iMemWData   in   32      core write data
//  oMemRData   out  32      read data, valid while oMemRdy=1 after a read
//  oMemRdy     out  1       response; drives core iMemRdy
//  oErr        out  1       access error (MEM_CHECK_EN only; tied 0 otherwise)
//  oRamEn      out  1       RAM enable, one-cycle pulse per access
//  oRamWe      out  1       RAM write enable, qualified by oRamEn
//  oRamAddr    out  ADDR_W  RAM word address = iMemAddr[ADDR_W+1:2]
//  oRamWData   out  32      RAM write data
//  iRamRData   in   32      RAM read data, valid RD_LAT cycles after oRamEn
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, including oMemRData. Counter 0. Latched address/data 0.
//  Reset has priority in every state; an abort mid-access re-enters IDLE on the next edge.
//  Writes: a write is performed iff its ACCESS edge has passed.
//  FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: on edge E0, if iMemRead|iMemWrite, latch addr/wdata/direction and go to ACCESS.
//   Latched values ignore core changes until back in IDLE.
//  ACCESS: oRamEn=1 (oRamWe=1 if write) for exactly one cycle.
//   On edge E1, load the counter with N = WAIT_STATES + (read ? RD_LAT : 0).
//   If N==0, go to RESP; otherwise go to WAIT.
//  WAIT: decrement the counter each edge.
//   iRamRData is captured into oMemRData on the edge closing the RD_LAT-th cycle after ACCESS.
//   Go to RESP on the edge where the counter reaches 0.
//  Latency: oMemRdy rises after edge E(1+WAIT_STATES+RD_LAT) for a read, E(1+WAIT_STATES) for a write.
//  RESP: oMemRdy=1 while either strobe stays high. Both low -> IDLE, with oMemRdy=0 after that edge.
//   No new access is issued while in RESP.
//  oMemRData holds its value until the next read capture; writes do not alter it.
//  Width: upper address bits [31:ADDR_W+2] and [1:0] are not decoded (aliasing) unless MEM_CHECK_EN.
//  Both strobes high in IDLE: write takes priority (without MEM_CHECK_EN).
// CONFIGURATION
//  MEM_CHECK_EN defined: in IDLE, a request is an error if any of the following holds:
//   - iMemAddr[1:0]!=0
//   - iMemAddr[31:ADDR_W+2]!=0
//   - both strobes are high
//  Error response: no RAM access; go to RESP on E0; oMemRdy=1, oErr=1, oMemRData=ERR_RDATA (32'hDEADBEEF).
//  oErr clears with oMemRdy.
//  MEM_CHECK_EN undefined: no checks, aliasing and write-priority as above; oErr constant 0.
// STRUCTURE
//  Package mem_bus_ctrl_pkg: state enum typedef (IDLE/ACCESS/WAIT/RESP); ERR_RDATA constant.
//  Single module. The counter and FSM are inline; no sub-module is warranted.
// TESTING
//  Reset with strobes high -> all outputs 0; no oRamEn while iRst=1.
//  RD_LAT=1, WAIT_STATES=0:
//   - write 0x100 / 0xCAFEF00D -> one oRamEn+oRamWe pulse, oRamAddr=0x40; oMemRdy after E1.
//   - read 0x100 -> oMemRData=0xCAFEF00D, oMemRdy after E2.
//  WAIT_STATES=3 read -> oMemRdy after E5; exactly one oRamEn pulse.
//  Hold iMemRead 6 cycles past oMemRdy -> single RAM access; drop strobe -> oMemRdy=0 next edge.
//  iRst asserted in WAIT -> IDLE next edge; oMemRdy never rises; a new read afterwards completes normally.
//  Read 0x102:
//   - with MEM_CHECK_EN -> no oRamEn; oMemRdy=oErr=1 after E0; data 0xDEADBEEF.
//   - without MEM_CHECK_EN -> RAM word 0x40 is read.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the memory bus controller.
// The state encoding and the error read-data pattern live here so the
// controller and anything observing it agree on them.
package mem_bus_ctrl_pkg;

    // Controller phases: wait for a request, pulse the RAM, wait out the
    // latency, then hold the response until the core drops its strobe.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Read data returned alongside an error response.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Memory-side controller between the RV32I core memory port and a pipelined
// synchronous word RAM. Each core request (a level strobe) produces exactly
// one single-cycle RAM access and a four-phase oMemRdy handshake.
//
// Optional feature: define MEM_CHECK_EN to flag misaligned, out-of-range and
// read+write requests with an error response instead of a RAM access.
// Without it the upper/lower address bits alias and a write wins over a read.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int RD_LAT      = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic [31:0]       iMemAddr,
    input  logic [31:0]       iMemWData,
    output logic [31:0]       oMemRData,
    output logic              oMemRdy,
    output logic              oErr,
    output logic              oRamEn,
    output logic              oRamWe,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [31:0]       oRamWData,
    input  logic [31:0]       iRamRData
);

    // Counter must hold the longest post-access delay (a read with wait states).
    localparam int CNT_MAX = WAIT_STATES + RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_READ  = CNT_W'(WAIT_STATES + RD_LAT);
    localparam logic [CNT_W-1:0] CNT_WRITE = CNT_W'(WAIT_STATES);
    // Counter value seen in WAIT on the edge closing the RD_LAT-th cycle after
    // the access: the RAM output is valid during exactly that cycle.
    localparam logic [CNT_W-1:0] CNT_CAPT  = CNT_W'(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_ram_en;
    logic                r_ram_we;
    logic                r_mem_rdy;
    logic                r_err;
    logic [31:0]         r_mem_rdata;

    logic                w_req;
    logic                w_req_err;
    logic [ADDR_W-1:0]   w_word_addr;
    logic [CNT_W-1:0]    w_load_n;

    assign w_req       = iMemRead | iMemWrite;
    assign w_word_addr = iMemAddr[ADDR_W+1:2];
    assign w_load_n    = r_is_write ? CNT_WRITE : CNT_READ;

`ifdef MEM_CHECK_EN
    logic [31:0] w_hi_bits;

    // Anything above the RAM's byte range must be zero for a legal request.
    assign w_hi_bits = iMemAddr >> (ADDR_W + 2);
    assign w_req_err = (iMemAddr[1:0] != 2'b00) | (w_hi_bits != 32'd0)
                     | (iMemRead & iMemWrite);
`else
    logic w_unused_addr_bits;

    // Undecoded address bits simply alias onto the RAM.
    assign w_unused_addr_bits = ^{iMemAddr[31:ADDR_W+2], iMemAddr[1:0]};
    assign w_req_err          = 1'b0;
`endif

    // Handshake FSM with every output registered; reset overrides any phase.
    always_ff @(posedge iClk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register in this block samples pre-edge values, like real flops.
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_mem_rdy   <= 1'b0;
            r_err       <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_req_err) begin
                            // Illegal request: answer immediately, RAM untouched.
                            r_state     <= ST_RESP;
                            r_mem_rdy   <= 1'b1;
                            r_err       <= 1'b1;
                            r_mem_rdata <= ERR_RDATA;
                        end else begin
                            // Freeze the request; the core may change its
                            // bus before we return to IDLE.
                            r_state    <= ST_ACCESS;
                            r_is_write <= iMemWrite;
                            r_addr     <= w_word_addr;
                            r_wdata    <= iMemWData;
                            r_ram_en   <= 1'b1;
                            r_ram_we   <= iMemWrite;
                        end
                    end
                end

                ST_ACCESS: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_cnt    <= w_load_n;
                    if (w_load_n == '0) begin
                        r_state   <= ST_RESP;
                        r_mem_rdy <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (!r_is_write && (r_cnt == CNT_CAPT)) begin
                        r_mem_rdata <= iRamRData;
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_state   <= ST_RESP;
                        r_mem_rdy <= 1'b1;
                    end
                end

                ST_RESP: begin
                    // Hold the response until the core releases both strobes.
                    if (!w_req) begin
                        r_state   <= ST_IDLE;
                        r_mem_rdy <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oMemRData = r_mem_rdata;
    assign oMemRdy   = r_mem_rdy;
    assign oErr      = r_err;
    assign oRamEn    = r_ram_en;
    assign oRamWe    = r_ram_we;
    assign oRamAddr  = r_addr;
    assign oRamWData = r_wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl. Two instances share the clock:
// dut_a (RD_LAT=1, WAIT_STATES=0) and dut_b (RD_LAT=1, WAIT_STATES=3), each
// with its own behavioural RAM. Expected responses are pushed to a scoreboard
// queue when a request is driven and popped when oMemRdy is seen.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int ADDR_W = 12;
    localparam int WORDS  = 1 << ADDR_W;
    localparam logic [31:0] IDLE_BUS = 32'h0BAD_0BAD;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic        err;
        int          ens;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // ---------------- DUT A ----------------
    logic              a_rst, a_rd, a_wr;
    logic [31:0]       a_addr, a_wdata, a_rdata, a_ram_wdata, a_ram_rdata;
    logic              a_rdy, a_err, a_ram_en, a_ram_we;
    logic [ADDR_W-1:0] a_ram_addr;
    logic [31:0]       a_mem [WORDS];
    logic [31:0]       ref_a [WORDS];
    logic [31:0]       a_last_rdata;
    int                a_en_cnt;
    logic              a_en_we;
    logic [ADDR_W-1:0] a_en_addr;

    mem_bus_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1), .WAIT_STATES(0)) dut_a (
        .iClk(clk), .iRst(a_rst), .iMemRead(a_rd), .iMemWrite(a_wr),
        .iMemAddr(a_addr), .iMemWData(a_wdata), .oMemRData(a_rdata),
        .oMemRdy(a_rdy), .oErr(a_err), .oRamEn(a_ram_en), .oRamWe(a_ram_we),
        .oRamAddr(a_ram_addr), .oRamWData(a_ram_wdata), .iRamRData(a_ram_rdata)
    );

    // ---------------- DUT B ----------------
    logic              b_rst, b_rd, b_wr;
    logic [31:0]       b_addr, b_wdata, b_rdata, b_ram_wdata, b_ram_rdata;
    logic              b_rdy, b_err, b_ram_en, b_ram_we;
    logic [ADDR_W-1:0] b_ram_addr;
    logic [31:0]       b_mem [WORDS];
    int                b_en_cnt;

    mem_bus_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1), .WAIT_STATES(3)) dut_b (
        .iClk(clk), .iRst(b_rst), .iMemRead(b_rd), .iMemWrite(b_wr),
        .iMemAddr(b_addr), .iMemWData(b_wdata), .oMemRData(b_rdata),
        .oMemRdy(b_rdy), .oErr(b_err), .oRamEn(b_ram_en), .oRamWe(b_ram_we),
        .oRamAddr(b_ram_addr), .oRamWData(b_ram_wdata), .iRamRData(b_ram_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // RAM models: one-cycle read latency; output is garbage outside the valid cycle.
    always @(posedge clk) begin
        a_ram_rdata <= IDLE_BUS;
        if (a_ram_en) begin
            if (a_ram_we) a_mem[a_ram_addr] <= a_ram_wdata;
            else          a_ram_rdata <= a_mem[a_ram_addr];
        end
    end

    always @(posedge clk) begin
        b_ram_rdata <= IDLE_BUS;
        if (b_ram_en) begin
            if (b_ram_we) b_mem[b_ram_addr] <= b_ram_wdata;
            else          b_ram_rdata <= b_mem[b_ram_addr];
        end
    end

    // RAM enable monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_ram_en) begin
            a_en_cnt  = a_en_cnt + 1;
            a_en_we   = a_ram_we;
            a_en_addr = a_ram_addr;
        end
        if (b_ram_en) b_en_cnt = b_en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One core transaction on dut_a; called and returning on a falling edge.
    task automatic a_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
        exp_t        e;
        int          n;
        int          word;
        logic        bad;
        logic        stayed;
        word = int'(addr[ADDR_W+1:2]);
`ifdef MEM_CHECK_EN
        bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 0) || (rd && wr);
`else
        bad = 1'b0;
`endif
        if (bad) begin
            e.data = ERR_RDATA; e.lat = 1; e.err = 1'b1; e.ens = 0;
            a_last_rdata = ERR_RDATA;
        end else if (wr) begin
            ref_a[word] = wdata;
            e.data = a_last_rdata; e.lat = 2; e.err = 1'b0; e.ens = 1;
        end else begin
            e.data = ref_a[word]; e.lat = 3; e.err = 1'b0; e.ens = 1;
            a_last_rdata = e.data;
        end
        sb_q.push_back(e);

        a_en_cnt = 0;
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (a_rdy) break;
        end
        e = sb_q.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        check("rdata", a_rdata, e.data);
        check("err", {31'd0, a_err}, {31'd0, e.err});
        check("ram_en_pulses", 32'(a_en_cnt), 32'(e.ens));
        if (e.ens == 1) begin
            check("ram_addr", {20'd0, a_en_addr}, 32'(word));
            check("ram_we", {31'd0, a_en_we}, {31'd0, wr});
        end
        if (hold > 0) begin
            stayed = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!a_rdy) stayed = 1'b0;
            end
            check("rdy_held", {31'd0, stayed}, 32'd1);
            check("no_reissue", 32'(a_en_cnt), 32'(e.ens));
        end
        a_rd = 1'b0; a_wr = 1'b0;
        a_addr = $urandom; a_wdata = $urandom;
        @(negedge clk);
        check("rdy_drop", {31'd0, a_rdy}, 32'd0);
        check("err_drop", {31'd0, a_err}, 32'd0);
    endtask

    // A read on dut_b (three wait states); called and returning on a falling edge.
    task automatic b_read(input logic [31:0] addr);
        exp_t e;
        int   n;
        e.data = init_val(int'(addr[ADDR_W+1:2])); e.lat = 6; e.err = 1'b0; e.ens = 1;
        sb_q.push_back(e);
        b_en_cnt = 0;
        b_rd = 1'b1; b_addr = addr;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (b_rdy) break;
        end
        e = sb_q.pop_front();
        check("b_latency", 32'(n), 32'(e.lat));
        check("b_rdata", b_rdata, e.data);
        check("b_ram_en_pulses", 32'(b_en_cnt), 32'(e.ens));
        b_rd = 1'b0;
        @(negedge clk);
        check("b_rdy_drop", {31'd0, b_rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic all_zero;
        logic rose;
        for (int i = 0; i < WORDS; i++) begin
            a_mem[i] = init_val(i);
            ref_a[i] = init_val(i);
            b_mem[i] = init_val(i);
        end
        a_en_cnt = 0; b_en_cnt = 0; a_en_we = 1'b0; a_en_addr = '0;
        a_last_rdata = 32'd0;

        // Reset with strobes high: nothing may move.
        a_rst = 1'b1; a_rd = 1'b1; a_wr = 1'b1; a_addr = 32'h100; a_wdata = 32'h1234_5678;
        b_rst = 1'b1; b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'h200; b_wdata = 32'd0;
        all_zero = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_rdy || a_err || a_ram_en || a_ram_we || (a_rdata != 0) ||
                (a_ram_addr != 0) || (a_ram_wdata != 0) || b_rdy || b_ram_en)
                all_zero = 1'b0;
        end
        check("reset_outputs", {31'd0, all_zero}, 32'd1);
        check("reset_no_ram_en", 32'(a_en_cnt + b_en_cnt), 32'd0);
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Basic write then read, then hold the read strobe six cycles.
        a_txn(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 0);
        a_txn(1'b1, 1'b0, 32'h0000_0100, 32'd0, 6);
        // Write leaves read data untouched; read it back.
        a_txn(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 2);
        a_txn(1'b1, 1'b0, 32'h0000_0104, 32'd0, 0);
        // Both strobes: write priority (or an error when checking is built in).
        a_txn(1'b1, 1'b1, 32'h0000_0108, 32'h0BAD_CAFE, 0);
        a_txn(1'b1, 1'b0, 32'h0000_0108, 32'd0, 0);
        // Misaligned and out-of-range addresses alias onto word 0x40 (or error).
        a_txn(1'b1, 1'b0, 32'h0000_0102, 32'd0, 1);
        a_txn(1'b1, 1'b0, 32'h0000_4100, 32'd0, 0);
        // Boundary words.
        a_txn(1'b0, 1'b1, 32'h0000_3FFC, 32'hA5A5_5A5A, 0);
        a_txn(1'b1, 1'b0, 32'h0000_3FFC, 32'd0, 0);
        a_txn(1'b1, 1'b0, 32'h0000_0000, 32'd0, 0);
        // Random mix in a small window so reads hit earlier writes.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ra;
            ra = 32'h800 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
            a_txn(1'b1 ^ k[0], k[0], ra, $urandom, int'($urandom_range(0, 2)));
        end

        // Wait states: read completes after E5 with a single RAM pulse.
        b_read(32'h0000_0200);

        // Reset while in WAIT: abort, no response, then a normal read.
        b_en_cnt = 0;
        b_rd = 1'b1; b_addr = 32'h0000_0300;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst = 1'b1; b_rd = 1'b0;
        @(negedge clk);
        b_rst = 1'b0;
        rose = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b_rdy) rose = 1'b1;
        end
        check("abort_no_rdy", {31'd0, rose}, 32'd0);
        check("abort_rdata_cleared", b_rdata, 32'd0);
        check("abort_one_access", 32'(b_en_cnt), 32'd1);
        b_read(32'h0000_0304);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
